pipe_latch: RTL and testbench

PIPE_LATCH -- requirements
Module: pipe_latch

---
 rtl/pipe_pkg.sv | 34 +++
 rtl/pipe_entry.sv | 26 ++
 rtl/pipe_latch.sv | 188 ++++++++++++++++++
 tb/tb_pipe_latch.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// Shared constants for the pipeline latch: payload packing, control-bit
// indices, skid-buffer state encoding and the saturating stall increment.
package pipe_pkg;

    localparam int DATA_W_DEF    = 16;
    localparam int CTRL_W_DEF    = 8;
    localparam int LANES_DEF     = 4;
    localparam int PAYLOAD_W_DEF = LANES_DEF * DATA_W_DEF;

    localparam int REG_WRITE = 0;
    localparam int MEM_READ  = 1;
    localparam int MEM_WRITE = 2;
    localparam int HALT      = 3;
    localparam int BRANCH    = 4;
    localparam int JUMP      = 5;

    localparam int          STALL_W   = 16;
    localparam logic [15:0] STALL_MAX = 16'hFFFF;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_FULL  = 2'd1,
        ST_SKID  = 2'd2
    } skid_state_t;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        if (v == STALL_MAX) begin
            return v;
        end else begin
            return v + 16'd1;
        end
    endfunction

endpackage

// File: rtl/pipe_entry.sv
// Width-parameterised entry register: clear beats load, async active-low reset.
module pipe_entry #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic         clr,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    // Entry storage; clear wins over load so a squash always leaves zeros.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            q <= {W{1'b0}};
        end else if (clr) begin
            q <= {W{1'b0}};
        end else if (en) begin
            q <= d;
        end else begin
            q <= q;
        end
    end

endmodule

// File: rtl/pipe_latch.sv
// Pipeline stage latch with flush, stall counter and an optional one-entry
// skid buffer enabled by defining PIPE_LATCH_SKID_EN.
module pipe_latch
    import pipe_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int CTRL_W = CTRL_W_DEF,
    parameter int LANES  = LANES_DEF
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [CTRL_W-1:0]         in_ctrl,
    input  logic [LANES*DATA_W-1:0]   in_data,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [CTRL_W-1:0]         out_ctrl,
    output logic [LANES*DATA_W-1:0]   out_data,
    input  logic                      flush,
    output logic [STALL_W-1:0]        stall_cnt
);

    localparam int PAYLOAD_W = LANES * DATA_W;
    localparam int ENTRY_W   = CTRL_W + PAYLOAD_W;

    logic               valid_r;
    logic               xfer_in_s;
    logic               xfer_out_s;
    logic               main_en_s;
    logic               main_clr_s;
    logic [ENTRY_W-1:0] main_d_s;
    logic [ENTRY_W-1:0] main_q_s;
    logic [STALL_W-1:0] stall_r;

    assign xfer_in_s  = in_valid & in_ready;
    assign xfer_out_s = valid_r & out_ready;

`ifdef PIPE_LATCH_SKID_EN
    skid_state_t        state_r;
    skid_state_t        state_n_s;
    logic               ready_r;
    logic               skid_en_s;
    logic               skid_clr_s;
    logic [ENTRY_W-1:0] skid_q_s;

    assign in_ready = ready_r;

    // Next state and entry load/clear decode for the EMPTY/FULL/SKID buffer.
    always_comb begin
        state_n_s  = state_r;
        main_en_s  = 1'b0;
        main_clr_s = 1'b0;
        main_d_s   = {in_ctrl, in_data};
        skid_en_s  = 1'b0;
        skid_clr_s = 1'b0;
        if (flush) begin
            state_n_s  = ST_EMPTY;
            main_clr_s = 1'b1;
            skid_clr_s = 1'b1;
        end else begin
            case (state_r)
                ST_EMPTY: begin
                    if (xfer_in_s) begin
                        state_n_s = ST_FULL;
                        main_en_s = 1'b1;
                    end else begin
                        state_n_s = ST_EMPTY;
                    end
                end
                ST_FULL: begin
                    if (xfer_in_s && xfer_out_s) begin
                        state_n_s = ST_FULL;
                        main_en_s = 1'b1;
                    end else if (xfer_in_s) begin
                        state_n_s = ST_SKID;
                        skid_en_s = 1'b1;
                    end else if (xfer_out_s) begin
                        state_n_s  = ST_EMPTY;
                        main_clr_s = 1'b1;
                    end else begin
                        state_n_s = ST_FULL;
                    end
                end
                ST_SKID: begin
                    // Skid entry moves up behind the one just consumed.
                    if (xfer_out_s) begin
                        state_n_s  = ST_FULL;
                        main_en_s  = 1'b1;
                        main_d_s   = skid_q_s;
                        skid_clr_s = 1'b1;
                    end else begin
                        state_n_s = ST_SKID;
                    end
                end
                default: begin
                    state_n_s  = ST_EMPTY;
                    main_clr_s = 1'b1;
                    skid_clr_s = 1'b1;
                end
            endcase
        end
    end

    // State plus registered valid/ready flags derived from the next state.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= ST_EMPTY;
            valid_r <= 1'b0;
            ready_r <= 1'b1;
        end else begin
            state_r <= state_n_s;
            valid_r <= (state_n_s != ST_EMPTY);
            ready_r <= (state_n_s != ST_SKID);
        end
    end

    pipe_entry #(.W(ENTRY_W)) u_skid (
        .clk (clk),
        .rst (rst),
        .en  (skid_en_s),
        .clr (skid_clr_s),
        .d   ({in_ctrl, in_data}),
        .q   (skid_q_s)
    );
`else
    assign in_ready = out_ready | ~valid_r;

    // Single-entry load/clear decode; draining clears so ctrl reads zero.
    always_comb begin
        main_en_s  = 1'b0;
        main_clr_s = 1'b0;
        main_d_s   = {in_ctrl, in_data};
        if (flush) begin
            main_clr_s = 1'b1;
        end else if (xfer_in_s) begin
            main_en_s = 1'b1;
        end else if (xfer_out_s) begin
            main_clr_s = 1'b1;
        end else begin
            main_en_s = 1'b0;
        end
    end

    // Occupancy flag of the single entry.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_r <= 1'b0;
        end else if (flush) begin
            valid_r <= 1'b0;
        end else if (xfer_in_s) begin
            valid_r <= 1'b1;
        end else if (xfer_out_s) begin
            valid_r <= 1'b0;
        end else begin
            valid_r <= valid_r;
        end
    end
`endif

    pipe_entry #(.W(ENTRY_W)) u_main (
        .clk (clk),
        .rst (rst),
        .en  (main_en_s),
        .clr (main_clr_s),
        .d   (main_d_s),
        .q   (main_q_s)
    );

    // Saturating count of stalled cycles; flush cycles are not counted.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_r <= 16'd0;
        end else if (flush) begin
            stall_r <= stall_r;
        end else if (valid_r && !out_ready) begin
            stall_r <= sat_inc16(stall_r);
        end else begin
            stall_r <= stall_r;
        end
    end

    assign out_valid = valid_r;
    assign out_ctrl  = main_q_s[ENTRY_W-1 -: CTRL_W];
    assign out_data  = main_q_s[PAYLOAD_W-1:0];
    assign stall_cnt = stall_r;

endmodule

// File: tb/tb_pipe_latch.sv
// Self-checking bench for pipe_latch: constant vector table, hand-written
// corner sequences and a queue-based random reference model.
module tb_pipe_latch;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [7:0]  in_ctrl = 8'h00;
    logic [63:0] in_data = 64'h0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [7:0]  out_ctrl;
    logic [63:0] out_data;
    logic        flush = 1'b0;
    logic [15:0] stall_cnt;

    int n_pass  = 0;
    int n_total = 0;

`ifdef PIPE_LATCH_SKID_EN
    localparam int CAP = 2;
`else
    localparam int CAP = 1;
`endif

    logic [71:0] mq[$];
    int          m_stall;

    typedef struct {
        bit          iv;
        logic [7:0]  c;
        logic [63:0] d;
        bit          ordy;
        bit          fl;
        bit          e_valid;
        logic [7:0]  e_ctrl;
        logic [15:0] e_lane0;
        logic [15:0] e_stall;
    } vec_t;

    always #5 clk = ~clk;

    pipe_latch #(.DATA_W(16), .CTRL_W(8), .LANES(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_ctrl   (in_ctrl),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_ctrl  (out_ctrl),
        .out_data  (out_data),
        .flush     (flush),
        .stall_cnt (stall_cnt)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic do_reset();
        in_valid = 1'b0; flush = 1'b0; out_ready = 1'b0;
        in_ctrl = 8'h00; in_data = 64'h0;
        rst = 1'b0;
        #12;
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        mq.delete();
        m_stall = 0;
    endtask

    task automatic apply(input bit iv, input logic [7:0] c, input logic [63:0] d,
                         input bit ordy, input bit fl);
        in_valid = iv; in_ctrl = c; in_data = d; out_ready = ordy; flush = fl;
        @(posedge clk); #1;
    endtask

    function automatic bit m_ready(input bit ordy);
`ifdef PIPE_LATCH_SKID_EN
        return mq.size() < CAP;
`else
        return (mq.size() == 0) || ordy;
`endif
    endfunction

    // One cycle against the queue model: entries leave in arrival order.
    task automatic mcycle(input bit iv, input logic [7:0] c, input logic [63:0] d,
                          input bit ordy, input bit fl);
        bit er;
        bit xi;
        bit xo;
        in_valid = iv; in_ctrl = c; in_data = d; out_ready = ordy; flush = fl;
        #2;
        er = m_ready(ordy);
        chk("rnd_in_ready", {63'd0, in_ready}, {63'd0, er});
        if (fl) begin
            mq.delete();
        end else begin
            xi = iv && er;
            xo = (mq.size() > 0) && ordy;
            if ((mq.size() > 0) && !ordy && (m_stall < 65535)) m_stall++;
            if (xo) void'(mq.pop_front());
            if (xi) mq.push_back({c, d});
        end
        @(posedge clk); #1;
        chk("rnd_out_valid", {63'd0, out_valid}, {63'd0, (mq.size() > 0)});
        if (mq.size() > 0) begin
            chk("rnd_out_ctrl", {56'd0, out_ctrl}, {56'd0, mq[0][71:64]});
            chk("rnd_out_data", out_data, mq[0][63:0]);
        end else begin
            chk("rnd_out_ctrl", {56'd0, out_ctrl}, 64'd0);
        end
        chk("rnd_stall_cnt", {48'd0, stall_cnt}, 64'(m_stall));
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t        tbl[7];
        bit          exp_skid;
        bit          rdy;
        bit          acc;
        bit          take;
        int          n_acc;
        int          idx;
        int          cyc;
        logic [63:0] d;
        logic [63:0] sent[3];
        logic [63:0] rcv[$];

`ifdef PIPE_LATCH_SKID_EN
        exp_skid = 1'b1;
`else
        exp_skid = 1'b0;
`endif
        tbl[0] = '{1'b1, 8'h21, 64'h0000_0000_0000_1234, 1'b1, 1'b0, 1'b1, 8'h21, 16'h1234, 16'd0};
        tbl[1] = '{1'b1, 8'h42, 64'h1111_2222_3333_5678, 1'b1, 1'b0, 1'b1, 8'h42, 16'h5678, 16'd0};
        tbl[2] = '{1'b0, 8'h00, 64'h0,                   1'b1, 1'b0, 1'b0, 8'h00, 16'h0000, 16'd0};
        tbl[3] = '{1'b1, 8'h3C, 64'h9999_8888_7777_ABCD, 1'b0, 1'b0, 1'b1, 8'h3C, 16'hABCD, 16'd0};
        tbl[4] = '{1'b0, 8'h00, 64'h0,                   1'b0, 1'b0, 1'b1, 8'h3C, 16'hABCD, 16'd1};
        tbl[5] = '{1'b0, 8'h00, 64'h0,                   1'b1, 1'b0, 1'b0, 8'h00, 16'h0000, 16'd1};
        tbl[6] = '{1'b1, 8'hFF, 64'h1111_1111_1111_1111, 1'b1, 1'b1, 1'b0, 8'h00, 16'h0000, 16'd1};

        do_reset();
        chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
        chk("rst_out_ctrl", {56'd0, out_ctrl}, 64'd0);
        chk("rst_out_data", out_data, 64'd0);
        chk("rst_stall", {48'd0, stall_cnt}, 64'd0);
        chk("rst_in_ready", {63'd0, in_ready}, 64'd1);

        for (int i = 0; i < 7; i++) begin
            apply(tbl[i].iv, tbl[i].c, tbl[i].d, tbl[i].ordy, tbl[i].fl);
            chk($sformatf("vec%0d_valid", i), {63'd0, out_valid}, {63'd0, tbl[i].e_valid});
            chk($sformatf("vec%0d_ctrl", i), {56'd0, out_ctrl}, {56'd0, tbl[i].e_ctrl});
            if (tbl[i].e_valid || tbl[i].fl)
                chk($sformatf("vec%0d_lane0", i), {48'd0, out_data[15:0]}, {48'd0, tbl[i].e_lane0});
            chk($sformatf("vec%0d_stall", i), {48'd0, stall_cnt}, {48'd0, tbl[i].e_stall});
        end

        // Backpressure: E1 held for five stalled cycles while E2 is offered.
        do_reset();
        apply(1'b1, 8'h11, 64'hAAAA_0000_0000_E1E1, 1'b0, 1'b0);
        in_ctrl = 8'h22; in_data = 64'hBBBB_0000_0000_E2E2;
        n_acc = 0;
        for (int i = 0; i < 5; i++) begin
            #2;
            rdy = in_ready;
            if (rdy) n_acc++;
            chk($sformatf("bp_in_ready%0d", i), {63'd0, rdy}, {63'd0, (i == 0) ? exp_skid : 1'b0});
            @(posedge clk); #1;
            chk($sformatf("bp_hold%0d", i), out_data, 64'hAAAA_0000_0000_E1E1);
        end
        chk("bp_stall5", {48'd0, stall_cnt}, 64'd5);
        chk("bp_accepts", 64'(n_acc), {63'd0, exp_skid});
        chk("bp_ctrl", {56'd0, out_ctrl}, 64'h11);

        // Flush with the skid (if any) occupied and a new entry incoming.
        apply(1'b1, 8'hFF, 64'hCCCC_0000_0000_3333, 1'b0, 1'b1);
        chk("fl_valid", {63'd0, out_valid}, 64'd0);
        chk("fl_ctrl", {56'd0, out_ctrl}, 64'd0);
        chk("fl_data", out_data, 64'd0);
        chk("fl_stall", {48'd0, stall_cnt}, 64'd5);
        apply(1'b0, 8'h00, 64'h0, 1'b1, 1'b0);
        chk("fl_lost_valid", {63'd0, out_valid}, 64'd0);
        chk("fl_in_ready", {63'd0, in_ready}, 64'd1);

        // Asynchronous reset mid-cycle, then accept on the first edge after release.
        apply(1'b1, 8'h5A, 64'h0000_0000_0000_C0DE, 1'b0, 1'b0);
        apply(1'b0, 8'h00, 64'h0, 1'b0, 1'b0);
        chk("ar_pre_valid", {63'd0, out_valid}, 64'd1);
        #2;
        rst = 1'b0;
        #1;
        chk("ar_valid", {63'd0, out_valid}, 64'd0);
        chk("ar_stall", {48'd0, stall_cnt}, 64'd0);
        chk("ar_ctrl", {56'd0, out_ctrl}, 64'd0);
        chk("ar_data", out_data, 64'd0);
        @(negedge clk);
        rst = 1'b1;
        in_valid = 1'b1; in_ctrl = 8'h01; in_data = 64'h0000_0000_0000_F00D; out_ready = 1'b1;
        @(posedge clk); #1;
        chk("ar_first_valid", {63'd0, out_valid}, 64'd1);
        chk("ar_first_lane0", {48'd0, out_data[15:0]}, 64'hF00D);
        in_valid = 1'b0;

        // Ordering of A, B, C under random downstream readiness.
        do_reset();
        sent[0] = 64'hA0A0_0000_0000_000A;
        sent[1] = 64'hB0B0_0000_0000_000B;
        sent[2] = 64'hC0C0_0000_0000_000C;
        rcv.delete();
        idx = 0;
        cyc = 0;
        while ((rcv.size() < 3) && (cyc < 200)) begin
            in_valid = (idx < 3);
            in_data = (idx < 3) ? sent[idx] : 64'h0;
            in_ctrl = 8'h0F;
            out_ready = 1'($urandom_range(0, 1));
            #2;
            acc = in_valid && in_ready;
            take = out_valid && out_ready;
            d = out_data;
            @(posedge clk); #1;
            if (acc) idx++;
            if (take) rcv.push_back(d);
            cyc++;
        end
        in_valid = 1'b0;
        chk("ord_count", 64'(rcv.size()), 64'd3);
        for (int i = 0; i < 3; i++)
            chk($sformatf("ord_entry%0d", i), (rcv.size() > i) ? rcv[i] : 64'h0, sent[i]);
        apply(1'b0, 8'h00, 64'h0, 1'b1, 1'b0);
        chk("ord_no_dup", {63'd0, out_valid}, 64'd0);

        // Randomised traffic against the queue model.
        do_reset();
        for (int i = 0; i < 1500; i++) begin
            mcycle(1'($urandom_range(0, 1)), 8'($urandom), {$urandom, $urandom},
                   1'($urandom_range(0, 2) != 0), ($urandom_range(0, 15) == 0));
        end

        // Saturation of the stall counter.
        do_reset();
        apply(1'b1, 8'h77, 64'h0000_0000_0000_5A5A, 1'b0, 1'b0);
        in_valid = 1'b0;
        repeat (70000) @(posedge clk);
        #1;
        chk("sat_stall", {48'd0, stall_cnt}, 64'hFFFF);
        repeat (3) @(posedge clk);
        #1;
        chk("sat_hold", {48'd0, stall_cnt}, 64'hFFFF);
        chk("sat_data", {48'd0, out_data[15:0]}, 64'h5A5A);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
